// File: rtl/adc_promediador.sv
// rtl/adc_promediador.sv - per-period averaging of interleaved Vdc1/Vdc2/Iref ADC samples
// Optional macro ADC_BYPASS_EN: pass samples straight through without averaging.
module adc_promediador #(
    parameter int N_PROM_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        adc_valid,
    input  logic [1:0]  adc_canal,
    input  logic [11:0] adc_dato,
    output logic [11:0] Vdc1,
    output logic [11:0] Vdc2,
    output logic [11:0] Iref,
    output logic        dato_nuevo,
    output logic        incompleto,
    output logic        error_canal
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            error_canal <= 1'b0;
        else if (adc_valid && adc_canal == 2'd3)
            error_canal <= 1'b1;
    end

`ifdef ADC_BYPASS_EN

    logic carga_iref;

    assign incompleto = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Vdc1       <= '0;
            Vdc2       <= '0;
            Iref       <= '0;
            carga_iref <= 1'b0;
            dato_nuevo <= 1'b0;
        end else begin
            carga_iref <= adc_valid && adc_canal == 2'd2;
            dato_nuevo <= carga_iref;
            if (adc_valid) begin
                case (adc_canal)
                    2'd0:    Vdc1 <= adc_dato;
                    2'd1:    Vdc2 <= adc_dato;
                    2'd2:    Iref <= adc_dato;
                    default: ;
                endcase
            end
        end
    end

`else

    localparam int AW = 12 + N_PROM_LOG2;
    localparam int CW = N_PROM_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(1) << N_PROM_LOG2;
    localparam logic [AW:0]   HALF     = (AW + 1)'(1) << (N_PROM_LOG2 - 1);

    typedef enum logic [1:0] {ESPERA, ACUMULA, PUBLICA} estado_t;

    estado_t       estado_q, estado_d;
    logic [AW-1:0] acc_q [0:2];
    logic [CW-1:0] cnt_q [0:2];
    logic [2:0]    hit, acc_en;
    logic          clr, publica, marca_inc, todos_llenos;
    logic [11:0]   rnd [0:2];

    // A sample is only useful while its channel still lacks samples this period.
    always_comb begin
        hit          = '0;
        todos_llenos = 1'b1;
        for (int c = 0; c < 3; c++) begin
            hit[c] = adc_valid && adc_canal == 2'(c) && cnt_q[c] != CNT_FULL;
            if ((cnt_q[c] + CW'(hit[c])) != CNT_FULL)
                todos_llenos = 1'b0;
            rnd[c] = 12'(({1'b0, acc_q[c]} + HALF) >> N_PROM_LOG2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            estado_q <= ESPERA;
        else
            estado_q <= estado_d;
    end

    always_comb begin
        estado_d  = estado_q;
        clr       = 1'b0;
        acc_en    = '0;
        publica   = 1'b0;
        marca_inc = 1'b0;
        case (estado_q)
            ESPERA: begin
                if (trigger) begin
                    clr      = 1'b1;
                    estado_d = ACUMULA;
                end
            end
            ACUMULA: begin
                if (trigger) begin
                    clr       = 1'b1;
                    marca_inc = 1'b1;
                end else begin
                    acc_en = hit;
                    if (todos_llenos)
                        estado_d = PUBLICA;
                end
            end
            PUBLICA: begin
                publica  = 1'b1;
                clr      = trigger;
                estado_d = trigger ? ACUMULA : ESPERA;
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (clr) begin
                    acc_q[c] <= '0;
                    cnt_q[c] <= '0;
                end else if (acc_en[c]) begin
                    acc_q[c] <= acc_q[c] + AW'(adc_dato);
                    cnt_q[c] <= cnt_q[c] + CW'(1);
                end
            end
        end
    end

    // Publication reads the accumulators before any same-edge clear takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Vdc1       <= '0;
            Vdc2       <= '0;
            Iref       <= '0;
            dato_nuevo <= 1'b0;
            incompleto <= 1'b0;
        end else begin
            dato_nuevo <= publica;
            incompleto <= marca_inc;
            if (publica) begin
                Vdc1 <= rnd[0];
                Vdc2 <= rnd[1];
                Iref <= rnd[2];
            end
        end
    end

`endif

endmodule

// File: tb/tb_adc_promediador.sv
// tb/tb_adc_promediador.sv - randomized and directed checks of adc_promediador against a period-level model
module tb_adc_promediador;

    localparam int N    = 3;
    localparam int FULL = 1 << N;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trigger = 1'b0;
    logic        adc_valid = 1'b0;
    logic [1:0]  adc_canal = 2'd0;
    logic [11:0] adc_dato = 12'd0;
    logic [11:0] Vdc1, Vdc2, Iref;
    logic        dato_nuevo, incompleto, error_canal;

    int compared   = 0;
    int mismatched = 0;

    int m_sum [3];
    int m_n   [3];
    bit m_coll, m_pend;
    int e_out [3];
    bit e_dn, e_inc, e_err;

    adc_promediador #(.N_PROM_LOG2(N)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .adc_valid(adc_valid),
        .adc_canal(adc_canal), .adc_dato(adc_dato),
        .Vdc1(Vdc1), .Vdc2(Vdc2), .Iref(Iref),
        .dato_nuevo(dato_nuevo), .incompleto(incompleto), .error_canal(error_canal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Period model: a period collects up to FULL samples per channel; a complete set publishes one edge later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_sum[c] = 0; m_n[c] = 0; e_out[c] = 0;
            end
            m_coll = 0; m_pend = 0; e_dn = 0; e_inc = 0; e_err = 0;
        end else begin
            e_dn  = 0;
            e_inc = 0;
            if (adc_valid && adc_canal == 2'd3) e_err = 1;
            if (m_pend) begin
                for (int c = 0; c < 3; c++) e_out[c] = (m_sum[c] + FULL / 2) / FULL;
                e_dn   = 1;
                m_pend = 0;
                m_coll = trigger;
                if (trigger) for (int c = 0; c < 3; c++) begin m_sum[c] = 0; m_n[c] = 0; end
            end else if (trigger) begin
                e_inc  = m_coll;
                m_coll = 1;
                for (int c = 0; c < 3; c++) begin m_sum[c] = 0; m_n[c] = 0; end
            end else if (m_coll && adc_valid && adc_canal != 2'd3 && m_n[adc_canal] < FULL) begin
                m_sum[adc_canal] += int'(adc_dato);
                m_n[adc_canal]++;
                if (m_n[0] == FULL && m_n[1] == FULL && m_n[2] == FULL) begin
                    m_coll = 0;
                    m_pend = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("vdc1", int'(Vdc1), e_out[0]);
        chk("vdc2", int'(Vdc2), e_out[1]);
        chk("iref", int'(Iref), e_out[2]);
        chk("dato_nuevo", int'(dato_nuevo), int'(e_dn));
        chk("incompleto", int'(incompleto), int'(e_inc));
        chk("error_canal", int'(error_canal), int'(e_err));
    end

    task automatic drv(input bit t, input bit v, input int c, input int d);
        trigger   = t;
        adc_valid = v;
        adc_canal = 2'(c);
        adc_dato  = 12'(d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 0, 0, 0);
    endtask

    task automatic full_set(input int v0, input int v1, input int v2);
        for (int i = 0; i < FULL; i++) begin
            drv(0, 1, 0, v0);
            drv(0, 1, 1, v1);
            drv(0, 1, 2, v2);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_vdc1", int'(Vdc1), 0);
        chk("rst_dn", int'(dato_nuevo), 0);
        chk("rst_err", int'(error_canal), 0);
        rst = 1'b0;
        idle(2);

        // Interleaved 1000/2000/3000 set, pulse two edges after the last accepted sample
        drv(1, 0, 0, 0);
        full_set(1000, 2000, 3000);
        chk("pulse_early", int'(dato_nuevo), 0);
        idle(1);
        chk("pulse_edge", int'(dato_nuevo), 1);
        idle(1);
        chk("pulse_len", int'(dato_nuevo), 0);
        chk("lit_vdc1", int'(Vdc1), 1000);
        chk("lit_vdc2", int'(Vdc2), 2000);
        chk("lit_iref", int'(Iref), 3000);

        // Full-scale and rounding
        drv(1, 0, 0, 0);
        for (int i = 0; i < FULL; i++) begin
            drv(0, 1, 0, 4095);
            drv(0, 1, 1, i);
            drv(0, 1, 2, 5);
        end
        idle(3);
        chk("lit_fullscale", int'(Vdc1), 4095);
        chk("lit_round", int'(Vdc2), 4);
        chk("lit_round5", int'(Iref), 5);

        // Incomplete period, then a clean set
        drv(1, 0, 0, 0);
        repeat (5) drv(0, 1, 2, 100);
        drv(1, 0, 0, 0);
        chk("lit_incompleto", int'(incompleto), 1);
        chk("lit_hold", int'(Iref), 5);
        full_set(10, 20, 30);
        idle(3);
        chk("lit_after_inc", int'(Iref), 30);

        // Surplus samples discarded
        drv(1, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            repeat (FULL) drv(0, 1, c, 100);
            repeat (2) drv(0, 1, c, 0);
        end
        idle(3);
        chk("lit_surplus0", int'(Vdc1), 100);
        chk("lit_surplus2", int'(Iref), 100);

        // Sticky channel error
        drv(0, 1, 3, 77);
        idle(1);
        chk("lit_err_set", int'(error_canal), 1);

        // Trigger during publication restarts accumulation
        drv(1, 0, 0, 0);
        for (int i = 0; i < FULL - 1; i++) begin
            drv(0, 1, 0, 1); drv(0, 1, 1, 2); drv(0, 1, 2, 3);
        end
        drv(0, 1, 0, 1); drv(0, 1, 1, 2); drv(0, 1, 2, 3);
        drv(1, 1, 0, 999);
        full_set(40, 50, 60);
        idle(3);

        for (int k = 0; k < 600; k++) begin
            int r, c;
            r = int'($urandom_range(0, 9));
            c = ($urandom_range(0, 49) == 0) ? 3 : int'($urandom_range(0, 2));
            drv($urandom_range(0, 69) == 0, $urandom_range(0, 3) != 0, c,
                (r == 0) ? 0 : (r == 1) ? 4095 : int'($urandom_range(0, 4095)));
        end
        idle(2);
        chk("lit_err_sticky", int'(error_canal), 1);

        // Asynchronous reset mid-accumulation
        drv(1, 0, 0, 0);
        full_set(500, 600, 700);
        idle(3);
        drv(1, 0, 0, 0);
        repeat (4) drv(0, 1, 1, 321);
        #2 rst = 1'b1;
        #1;
        chk("async_vdc1", int'(Vdc1), 0);
        chk("async_iref", int'(Iref), 0);
        chk("async_err", int'(error_canal), 0);
        @(negedge clk);
        rst = 1'b0;
        full_set(11, 22, 33);
        idle(3);
        chk("lit_no_trig", int'(Vdc2), 0);
        drv(1, 0, 0, 0);
        full_set(11, 22, 33);
        idle(3);
        chk("lit_post_rst", int'(Vdc2), 22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adc_promediador.md
ADC_PROMEDIADOR -- requirements
Module: adc_promediador

Interface
REQ-001 SHALL have parameter N_PROM_LOG2, default 3, meaning log2 of samples averaged per channel per DAB period; legal range 1..6.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz).
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port trigger  input  1  one-cycle pulse marking start of a DAB switching period.
REQ-005 SHALL have port adc_valid  input  1  adc_canal/adc_dato valid this cycle.
REQ-006 SHALL have port adc_canal  input  2  source channel: 0=Vdc1, 1=Vdc2, 2=Iref, 3=illegal.
REQ-007 SHALL have port adc_dato  input  12  unsigned ADC code.
REQ-008 SHALL have ports Vdc1, Vdc2, Iref  output  12 each  averaged unsigned codes for the calibration stage.
REQ-009 SHALL have port dato_nuevo  output  1  one-cycle pulse when all three outputs update.
REQ-010 SHALL have port incompleto  output  1  one-cycle pulse when a period ends without a full sample set.
REQ-011 SHALL have port error_canal  output  1  sticky flag, set by a valid sample on channel 3.

Function
REQ-012 SHALL implement FSM states ESPERA, ACUMULA, PUBLICA.
REQ-013 ESPERA: on trigger, clear all accumulators and per-channel counters, go to ACUMULA; samples otherwise ignored.
REQ-014 ACUMULA: each adc_valid sample on channel c (0..2) SHALL be added to acc[c] and increment cnt[c] only while cnt[c] < 2^N_PROM_LOG2; surplus samples discarded.
REQ-015 Accumulators SHALL be 12+N_PROM_LOG2 bits unsigned; counters N_PROM_LOG2+1 bits.
REQ-016 When the edge that accepts a sample makes all three counters equal 2^N_PROM_LOG2, FSM SHALL enter PUBLICA on that edge.
REQ-017 PUBLICA: on the next edge, each output SHALL load (acc[c] + 2^(N_PROM_LOG2-1)) >> N_PROM_LOG2, dato_nuevo SHALL be 1 for exactly that cycle, FSM returns to ESPERA.
REQ-018 Rounded result SHALL never exceed 4095; no saturation logic is needed, arithmetic width must prevent carry loss.
REQ-019 trigger in ACUMULA (set incomplete): outputs hold previous values, incompleto pulses one cycle, accumulators/counters clear, FSM stays in ACUMULA.
REQ-020 trigger in PUBLICA: publication completes as REQ-017, FSM goes to ACUMULA with cleared accumulators instead of ESPERA.
REQ-021 trigger coincident with a valid sample: the clear has priority; that sample is discarded.
REQ-022 Outputs SHALL change only on publication; they stay stable between dato_nuevo pulses.
REQ-023 error_canal SHALL be set by any adc_valid with adc_canal=3 in any state and clear only on rst.

Reset
REQ-024 On rst=1, immediately and independent of clk: FSM=ESPERA, acc/cnt=0, Vdc1=Vdc2=Iref=0, dato_nuevo=0, incompleto=0, error_canal=0.
REQ-025 Reset mid-accumulation SHALL discard partial sums; first publication after release requires a trigger plus full sample set.

Configuration
REQ-026 Macro ADC_BYPASS_EN: when undefined, behaviour per REQ-012..023.
REQ-027 When ADC_BYPASS_EN is defined: FSM and accumulators removed; each valid sample on channel 0..2 loads its output unmodified on the next edge; dato_nuevo pulses the cycle after each channel-2 load; trigger ignored; incompleto tied 0; error_canal unchanged.

Verification
REQ-028 N=3, trigger, 8 samples each channel of 1000, 2000, 3000 interleaved -> Vdc1=1000, Vdc2=2000, Iref=3000, one dato_nuevo pulse two edges after last accepted sample.
REQ-029 N=3, channel 0 samples 4095 x8 -> Vdc1=4095; channel 1 samples 0..7 (sum 28, +4, >>3) -> Vdc2=4.
REQ-030 Trigger after only 5 Iref samples -> incompleto pulse, outputs unchanged, next full set publishes correctly.
REQ-031 Extra 9th/10th samples per channel with value 0 after 8 x 100 -> discarded, output 100.
REQ-032 adc_canal=3 valid once -> error_canal=1 and stays 1 through further publications until rst.
REQ-033 rst asserted mid-ACUMULA with no clk edge -> all outputs 0 immediately; ADC_BYPASS_EN build: channel 2 sample 1234 -> Iref=1234 next edge, dato_nuevo one cycle later.
